updown_count_ctrl: RTL and testbench

//   Control FSM that drives the 5-bit up/down item counter: cntU, cntD, rst5.

---
 rtl/updown_count_ctrl.sv | 132 +++++++++++++
 tb/tb_updown_count_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_count_ctrl.sv
// ---------------------------------------------------------------------------
// updown_count_ctrl
//   Control FSM for an external W-bit up/down item counter. A run is:
//   IDLE -> CLEAR (clear the counter) -> FILL (count accepted input items up
//   until the item flagged last) -> DRAIN (emit one token per count while
//   counting down to zero) -> DONE (one-cycle done pulse) -> IDLE.
//
//   Optional feature macro: OVF_FLAG_EN adds a sticky overflow flag "ovf"
//   that records an input item presented while the counter was full.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (also clears the counter)
//   start      begin a run; only looked at in IDLE
//   in_valid   input item present
//   in_last    final item of the fill burst (qualifies in_valid)
//   in_ready   input item accepted when in_valid & in_ready
//   out_valid  drain token present
//   out_ready  drain token consumed when out_valid & out_ready
//   out_idx    token index (result - 1), 0 when out_valid is low
//   cntU       counter increment strobe
//   cntD       counter decrement strobe
//   rst5       counter clear strobe
//   result     counter value
//   down_done  counter == 0
//   busy       high in every state except IDLE
//   done       one-cycle pulse at the end of a run
//   ovf        (OVF_FLAG_EN only) sticky overflow flag
// ---------------------------------------------------------------------------
module updown_count_ctrl #(
  parameter int W         = 5,
  parameter int MAX_COUNT = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         cntU,
  output logic         cntD,
  output logic         rst5,
  input  logic [W-1:0] result,
  input  logic         down_done,
  output logic         busy,
  output logic         done
`ifdef OVF_FLAG_EN
  ,
  output logic         ovf
`endif
);

  localparam logic [W-1:0] MAX_V = W'(MAX_COUNT);
  localparam logic [W-1:0] ONE_V = W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FILL  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake strobes are Mealy: they depend on the live counter value and
  // the partner's valid/ready in the same cycle.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    cntU      = 1'b0;
    cntD      = 1'b0;
    rst5      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        rst5      = 1'b1;
        state_nxt = FILL;
      end
      FILL: begin
        // Holding in_ready low at full stalls the producer instead of
        // letting the counter wrap; a pending last item waits as well.
        in_ready = (result != MAX_V);
        cntU     = in_valid & in_ready;
        if (cntU && in_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        // down_done rises the cycle after the final decrement, so the
        // counter is never decremented at zero.
        out_valid = ~down_done;
        cntD      = out_valid & out_ready;
        if (out_valid) out_idx = result - ONE_V;
        if (down_done) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)
      ovf <= 1'b0;
    else if (state == IDLE && start)
      ovf <= 1'b0;
    else if (state == FILL && in_valid && result == MAX_V)
      ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_updown_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_updown_count_ctrl
//   Bench for updown_count_ctrl. Contains a behavioural model of the 5-bit
//   up/down counter the controller drives, and procedural run sequences
//   (fill, drain, done) whose expected handshakes, token indices and counts
//   come from the run length and the randomised valid/ready choices.
// ---------------------------------------------------------------------------
module tb_updown_count_ctrl;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         cntU;
  logic         cntD;
  logic         rst5;
  logic [W-1:0] result;
  logic         down_done;
  logic         busy;
  logic         done;
`ifdef OVF_FLAG_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] cnt;

  always #5 clk = ~clk;

  updown_count_ctrl #(.W(W), .MAX_COUNT(31)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .cntU      (cntU),
    .cntD      (cntD),
    .rst5      (rst5),
    .result    (result),
    .down_done (down_done),
    .busy      (busy),
    .done      (done)
`ifdef OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  // External counter the controller is meant to drive.
  always_ff @(posedge clk) begin
    if (rst || rst5)  cnt <= '0;
    else if (cntU)    cnt <= cnt + 5'd1;
    else if (cntD)    cnt <= cnt - 5'd1;
  end
  assign result    = cnt;
  assign down_done = (cnt == 5'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef OVF_FLAG_EN
    check(tag, 32'(ovf), 32'(exp));
`endif
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_busy"},     32'(busy),      0);
    check({tag, "_done"},     32'(done),      0);
    check({tag, "_strobes"},  {29'd0, cntU, cntD, rst5}, 0);
    check({tag, "_in_ready"}, 32'(in_ready),  0);
    check({tag, "_out_valid"},32'(out_valid), 0);
    check({tag, "_out_idx"},  32'(out_idx),   0);
  endtask

  // Start sampled in IDLE, then one clear cycle, FILL begins next.
  task automatic begin_run(input string tag);
    @(negedge clk); start = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; #1;
    check({tag, "_start_idle"}, 32'(busy), 0);
    check({tag, "_start_rst5"}, 32'(rst5), 0);
    @(negedge clk); start = 1'b0; #1;
    check({tag, "_clr_rst5"},  32'(rst5),     1);
    check({tag, "_clr_busy"},  32'(busy),     1);
    check({tag, "_clr_ready"}, 32'(in_ready), 0);
    check_ovf({tag, "_clr_ovf"}, 1'b0);
  endtask

  // Full run of n items: p_valid percent for in_valid, p_ready percent for
  // out_ready (negative: strictly alternating 1,0,1,0...). Returns number of
  // drain cycles taken.
  task automatic run(input string tag, input int n, input int p_valid,
                     input int p_ready, input bit poke_start, output int dcyc);
    int accepted, tokens, guard;
    begin_run(tag);
    accepted = 0;
    guard = 0;
    while (accepted < n && guard < 1000) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 99) < p_valid);
      in_last  = in_valid && (accepted == n - 1);
      #1;
      check({tag, "_fill_ready"}, 32'(in_ready), 1);
      check({tag, "_fill_cntU"},  32'(cntU), 32'(in_valid));
      check({tag, "_fill_cnt"},   32'(cnt), 32'(accepted));
      check({tag, "_fill_other"}, {30'd0, cntD, rst5}, 0);
      if (in_valid) accepted++;
      guard++;
    end
    check({tag, "_fill_timeout"}, 32'(accepted), 32'(n));
    tokens = 0;
    dcyc = 0;
    while (tokens < n && dcyc < 1000) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = (p_ready < 0) ? ((dcyc % 2) == 0) : ($urandom_range(0, 99) < p_ready);
      start     = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check({tag, "_drn_valid"}, 32'(out_valid), 1);
      check({tag, "_drn_idx"},   32'(out_idx), 32'(n - 1 - tokens));
      check({tag, "_drn_cntD"},  32'(cntD), 32'(out_ready));
      check({tag, "_drn_other"}, {30'd0, cntU, rst5}, 0);
      check({tag, "_drn_cnt"},   32'(cnt), 32'(n - tokens));
      if (out_ready) tokens++;
      dcyc++;
    end
    check({tag, "_drn_timeout"}, 32'(tokens), 32'(n));
    @(negedge clk); start = 1'b0; out_ready = 1'b1; #1;
    check({tag, "_zero_valid"}, 32'(out_valid), 0);
    check({tag, "_zero_cntD"},  32'(cntD), 0);
    check({tag, "_zero_cnt"},   32'(cnt), 0);
    check({tag, "_zero_done"},  32'(done), 0);
    @(negedge clk); out_ready = 1'b0; #1;
    check({tag, "_done"},      32'(done), 1);
    check({tag, "_done_busy"}, 32'(busy), 1);
    check({tag, "_done_cnt"},  32'(cnt), 0);
    @(negedge clk); #1;
    idle_checks({tag, "_after"});
    check_ovf({tag, "_ovf"}, 1'b0);
  endtask

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;

    // Reset held two cycles.
    @(negedge clk); @(negedge clk); #1;
    idle_checks("rst");
    check("rst_cnt", 32'(cnt), 0);
    check_ovf("rst_ovf", 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    idle_checks("rst_rel");

    // Three items, always ready.
    run("three", 3, 100, 100, 1'b0, dc);
    check("three_drain_cycles", 32'(dc), 3);

    // Fill to full, then last item stalls.
    begin_run("full");
    for (int i = 0; i < 31; i++) begin
      @(negedge clk); in_valid = 1'b1; in_last = 1'b0; #1;
      check("full_fill_ready", 32'(in_ready), 1);
      check("full_fill_cntU",  32'(cntU), 1);
      check("full_fill_cnt",   32'(cnt), 32'(i));
    end
    check_ovf("full_pre_ovf", 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = 1'b1; in_last = 1'b1; #1;
      check("full_stall_ready", 32'(in_ready), 0);
      check("full_stall_cntU",  32'(cntU), 0);
      check("full_stall_cnt",   32'(cnt), 31);
      check("full_stall_busy",  32'(busy), 1);
      if (k > 0) check_ovf("full_ovf_set", 1'b1);
    end
    @(negedge clk); rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    idle_checks("full_rst");
    check("full_rst_cnt", 32'(cnt), 0);
    check_ovf("full_rst_ovf", 1'b0);

    // Alternating out_ready on a count of 4.
    run("alt", 4, 100, -1, 1'b0, dc);
    check("alt_drain_cycles", 32'(dc), 7);

    // start pulsed while draining must be ignored.
    run("poke", 6, 70, 60, 1'b1, dc);

    // Reset in the middle of FILL at count 7.
    begin_run("mid");
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); in_valid = 1'b1; in_last = 1'b0; #1;
      check("mid_fill_cntU", 32'(cntU), 1);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    check("mid_cnt7", 32'(cnt), 7);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    idle_checks("mid_rst");
    check("mid_rst_cnt", 32'(cnt), 0);
    run("mid_again", 5, 80, 80, 1'b0, dc);

    // Randomised runs, including the 1 and 31 extremes.
    run("len1", 1, 50, 50, 1'b1, dc);
    run("len31", 31, 90, 90, 1'b0, dc);
    for (int r = 0; r < 6; r++) begin
      run("rand", $urandom_range(1, 31), $urandom_range(30, 100),
          $urandom_range(30, 100), 1'($urandom_range(0, 1)), dc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
